// File: rtl/apb_cmd_master.sv
// Single-outstanding APB3 master: valid/ready command in, valid/ready response out.
// Adds an access-phase timeout and rejects misaligned addresses without touching the bus.
module apb_cmd_master #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   state_e            state_q, state_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   always_comb begin
      state_d       = state_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      cnt_d         = cnt_q;
      case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               pwrite_d = cmd_write;
               paddr_d  = cmd_addr;
               pwdata_d = cmd_wdata;
               cnt_d    = '0;
               if (cmd_addr[1:0] != 2'b00) begin
                  rsp_err_d     = 1'b1;
                  rsp_timeout_d = 1'b0;
                  rsp_rdata_d   = '0;
                  state_d       = StResp;
               end else begin
                  state_d = StSetup;
               end
            end
         end
         StSetup: begin
            cnt_d   = '0;
            state_d = StAccess;
         end
         StAccess: begin
            // pready has priority over an expiring wait counter on the same edge
            if (pready) begin
               rsp_rdata_d   = pwrite_q ? '0 : prdata;
               rsp_err_d     = pslverr;
               rsp_timeout_d = 1'b0;
               state_d       = StResp;
            end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               state_d       = StResp;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q       <= StIdle;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         cnt_q         <= cnt_d;
      end
   end

   // Bus strobes decode straight from the state flop so reset releases them asynchronously
   assign cmd_ready   = (state_q == StIdle) && presetn;
   assign psel        = (state_q == StSetup) || (state_q == StAccess);
   assign penable     = (state_q == StAccess);
   assign rsp_valid   = (state_q == StResp);
   assign pwrite      = pwrite_q;
   assign paddr       = paddr_q;
   assign pwdata      = pwdata_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Randomized bench for apb_cmd_master: a behavioural APB slave plus a transaction-level
// model that predicts phase counts, latency and response fields for each command.
module tb_apb_cmd_master;

   localparam int unsigned TO = 16;

   logic        pclk, presetn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata, prdata;
   logic        pready, pslverr;

   int total = 0;
   int bad   = 0;
   logic [31:0] mem [64];

   apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .pclk(pclk), .presetn(presetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Issue one command at a negedge; the slave inserts 'waits' wait states (>= TO never ready).
   task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int waits, input logic serr, input int hold);
      int          n_setup, n_access, lat, acc, exp_setup, exp_access;
      logic        exp_err, exp_to, stab, busy_ok, resp_ok;
      logic [31:0] exp_rd, rd0;
      logic        err0, to0;
      check_eq("cmd_ready_idle", cmd_ready, 1);
      if (addr[1:0] != 2'b00) begin
         exp_setup = 0; exp_access = 0; exp_err = 1; exp_to = 0; exp_rd = 0;
      end else if (waits >= int'(TO)) begin
         exp_setup = 1; exp_access = TO; exp_err = 1; exp_to = 1; exp_rd = 0;
      end else begin
         exp_setup = 1; exp_access = waits + 1; exp_err = serr; exp_to = 0;
         exp_rd = (wr || serr) ? 32'h0 : mem[addr[7:2]];
      end
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
      @(posedge pclk);
      @(negedge pclk);
      // Scramble the command inputs: the DUT must use its registered copy
      cmd_valid = 1'b0; cmd_write = $urandom_range(0, 1); cmd_addr = $urandom;
      cmd_wdata = $urandom;
      lat = 1; n_setup = 0; n_access = 0; acc = 0; stab = 1; busy_ok = 1;
      while (!rsp_valid && lat < 100) begin
         if (cmd_ready) busy_ok = 0;
         pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
         if (psel) begin
            if (paddr !== addr || pwrite !== wr || pwdata !== wd) stab = 0;
            if (penable) begin
               n_access++;
               acc++;
               if (acc > waits) begin
                  pready  = 1'b1;
                  pslverr = serr;
                  if (serr) prdata = 32'h0;
                  else if (!pwrite) prdata = mem[paddr[7:2]];
                  else mem[paddr[7:2]] = pwdata;
               end
            end else begin
               n_setup++;
               pready = $urandom_range(0, 1);
            end
         end
         @(negedge pclk);
         lat++;
      end
      pready = 1'b0; pslverr = 1'b0;
      check_eq("latency", lat, exp_setup + exp_access + 1);
      check_eq("setup_cycles", n_setup, exp_setup);
      check_eq("access_cycles", n_access, exp_access);
      check_eq("bus_stable", stab, 1);
      check_eq("cmd_ready_busy", busy_ok, 1);
      check_eq("resp_psel", {psel, penable}, 2'b00);
      check_eq("rsp_err", rsp_err, exp_err);
      check_eq("rsp_timeout", rsp_timeout, exp_to);
      check_eq("rsp_rdata", rsp_rdata, exp_rd);
      rd0 = rsp_rdata; err0 = rsp_err; to0 = rsp_timeout; resp_ok = 1;
      for (int i = 0; i < hold; i++) begin
         rsp_ready = 1'b0;
         @(negedge pclk);
         if (!rsp_valid || cmd_ready || psel || rsp_rdata !== rd0 || rsp_err !== err0 ||
             rsp_timeout !== to0) resp_ok = 0;
      end
      if (hold > 0) check_eq("backpressure_hold", resp_ok, 1);
      rsp_ready = 1'b1;
      @(posedge pclk);
      @(negedge pclk);
      rsp_ready = $urandom_range(0, 1);
      check_eq("rsp_released", rsp_valid, 0);
      check_eq("cmd_ready_back", cmd_ready, 1);
   endtask

   initial begin
      logic        wr, serr, ok;
      logic [31:0] addr;
      int          waits, hold, sel;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[4] = 32'hDEAD_BEEF;
      presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
      #23;
      check_eq("rst_strobes", {cmd_ready, psel, penable, pwrite, rsp_valid, rsp_err,
                               rsp_timeout}, 7'b0);
      check_eq("rst_data", {paddr, pwdata, rsp_rdata}, 96'h0);
      @(negedge pclk);
      presetn = 1'b1;
      @(negedge pclk);

      run_txn(1'b1, 32'h08, 32'h1234_5678, 0, 1'b0, 0);
      run_txn(1'b0, 32'h08, 32'hAAAA_5555, 0, 1'b0, 0);
      check_eq("mem_08", mem[2], 32'h1234_5678);
      run_txn(1'b0, 32'h10, 32'h0, 3, 1'b0, 1);
      run_txn(1'b0, 32'h20, 32'h0, 99, 1'b0, 0);
      run_txn(1'b0, 32'h08, 32'h0, TO - 1, 1'b0, 0);
      run_txn(1'b1, 32'h06, 32'hCAFE_F00D, 0, 1'b0, 0);
      run_txn(1'b0, 32'h0C, 32'h0, 1, 1'b1, 0);
      run_txn(1'b1, 32'h14, 32'h5A5A_0001, 2, 1'b0, 5);

      // Reset in the middle of an access phase
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10;
      @(posedge pclk);
      @(negedge pclk);
      cmd_valid = 1'b0;
      @(negedge pclk);
      check_eq("pre_rst_access", {psel, penable}, 2'b11);
      #2 presetn = 1'b0;
      #1;
      check_eq("rst_async_bus", {psel, penable, cmd_ready, rsp_valid}, 4'b0);
      @(negedge pclk);
      @(negedge pclk);
      presetn = 1'b1;
      rsp_ready = 1'b0;
      ok = 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge pclk);
         if (rsp_valid || psel || !cmd_ready) ok = 0;
      end
      check_eq("no_rsp_after_rst", ok, 1);

      for (int n = 0; n < 40; n++) begin
         wr   = $urandom_range(0, 1);
         addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
         if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
         sel   = $urandom_range(0, 9);
         waits = (sel == 0) ? TO + 2 : (sel == 1) ? TO - 1 : $urandom_range(0, 4);
         serr  = ($urandom_range(0, 5) == 0);
         hold  = $urandom_range(0, 3);
         run_txn(wr, addr, $urandom, waits, serr, hold);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
